div_result_bcd: RTL and testbench

DIV_RESULT_BCD -- requirements
Module: div_result_bcd

---
 rtl/div_result_bcd.sv | 122 ++++++++++++
 tb/tb_div_result_bcd.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/div_result_bcd.sv
// div_result_bcd -- converts the 8/4-bit divider results to BCD.
//
// Ports:
//   CLK    in   clock, all state updates on the rising edge
//   RST    in   asynchronous active-high reset
//   START  in   request pulse, sampled only while idle
//   Q[8:0] in   binary quotient, latched on the accepting START edge
//   R[3:0] in   binary remainder, latched on the accepting START edge
//   Y[3:0] in   divisor, latched on the accepting START edge (zero check only)
//   BUSY   out  high while a conversion is in progress
//   DONE   out  one-cycle pulse when new results are presented
//   Q_BCD  out  quotient as three BCD digits {hundreds, tens, ones}
//   R_BCD  out  remainder as two BCD digits {tens, ones}
//   DZ     out  divide-by-zero flag of the last completed conversion
//
// The quotient takes 9 double-dabble steps, one per clock. The remainder
// never exceeds 15, so its conversion is a single compare-and-subtract.
module div_result_bcd (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [8:0]  Q,
  input  logic [3:0]  R,
  input  logic [3:0]  Y,
  output logic        BUSY,
  output logic        DONE,
  output logic [11:0] Q_BCD,
  output logic [7:0]  R_BCD,
  output logic        DZ
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DONE_S = 2'd2
  } state_t;

  state_t      state_q;
  logic [8:0]  qsh_q;   // quotient bits still to be shifted in, MSB first
  logic [3:0]  r_q;
  logic        yz_q;    // latched divisor was zero
  logic [11:0] bcd_q;   // BCD accumulator
  logic [3:0]  cnt_q;   // completed shift steps

  logic [11:0] adj;
  logic [11:0] bcd_d;
  logic [7:0]  r_bcd_d;

  // One double-dabble step: correct every digit >= 5, then shift in the next bit.
  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_d = {adj[10:0], qsh_q[8]};
  end

  always_comb begin
    r_bcd_d = {4'd0, r_q};
    if (r_q >= 4'd10) begin
      r_bcd_d = {4'd1, r_q - 4'd10};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      qsh_q   <= '0;
      r_q     <= '0;
      yz_q    <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      Q_BCD   <= '0;
      R_BCD   <= '0;
      DZ      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            qsh_q   <= Q;
            r_q     <= R;
            yz_q    <= (Y == 4'd0);
            bcd_q   <= '0;
            cnt_q   <= '0;
            BUSY    <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          qsh_q <= {qsh_q[7:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd8) begin
            // Ninth step: bcd_d already holds the complete quotient.
            Q_BCD   <= yz_q ? 12'h000 : bcd_d;
            R_BCD   <= yz_q ? 8'h00 : r_bcd_d;
            DZ      <= yz_q;
            DONE    <= 1'b1;
            cnt_q   <= '0;
            state_q <= DONE_S;
          end
        end
        DONE_S: begin
          DONE    <= 1'b0;
          BUSY    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          DONE    <= 1'b0;
          BUSY    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_result_bcd.sv
module tb_div_result_bcd;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [8:0]  Q;
  logic [3:0]  R;
  logic [3:0]  Y;
  logic        BUSY;
  logic        DONE;
  logic [11:0] Q_BCD;
  logic [7:0]  R_BCD;
  logic        DZ;

  div_result_bcd dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .Q     (Q),
    .R     (R),
    .Y     (Y),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .Q_BCD (Q_BCD),
    .R_BCD (R_BCD),
    .DZ    (DZ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] eq;
    logic [7:0]  er;
    logic        edz;
  } exp_t;

  typedef struct {
    logic [8:0]  q;
    logic [3:0]  r;
    logic [3:0]  y;
    logic [11:0] eq;
    logic [7:0]  er;
    logic        edz;
  } vec_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, expv);
    end
  endtask

  // Decimal reference for the quotient digits.
  function automatic logic [11:0] ref_q(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  function automatic logic [7:0] ref_r(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Scoreboard: every DONE pulse consumes one expected result.
  always @(negedge CLK) begin
    if (!RST && DONE) begin
      done_cnt++;
      chk("busy_with_done", 32'(BUSY), 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("q_bcd", 32'(Q_BCD), 32'(e.eq));
        chk("r_bcd", 32'(R_BCD), 32'(e.er));
        chk("dz", 32'(DZ), 32'(e.edz));
      end
    end
  end

  // Called at a negedge while idle: drives a START pulse, pushes the
  // expected result, waits for DONE and returns at the negedge after the
  // return to IDLE, so a following call runs back-to-back.
  task automatic conv(input logic [8:0] q, input logic [3:0] r, input logic [3:0] y,
                      input logic [11:0] eq, input logic [7:0] er, input logic edz);
    int n;
    exp_t e;
    e.eq = eq; e.er = er; e.edz = edz;
    Q = q; R = r; Y = y; START = 1'b1;
    exp_q.push_back(e);
    @(negedge CLK);
    START = 1'b0;
    if (BUSY !== 1'b1) chk("busy_after_start", 32'(BUSY), 32'd1);
    n = 1;
    while (DONE !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n != 10) chk("done_latency", 32'(n), 32'd10);
    @(negedge CLK);
    if (BUSY !== 1'b0 || DONE !== 1'b0) chk("idle_after_done", {30'd0, BUSY, DONE}, 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int d0;
    vecs[0] = '{q: 9'd13,  r: 4'd4,  y: 4'd5, eq: 12'h013, er: 8'h04, edz: 1'b0};
    vecs[1] = '{q: 9'd255, r: 4'd0,  y: 4'd1, eq: 12'h255, er: 8'h00, edz: 1'b0};
    vecs[2] = '{q: 9'd511, r: 4'd15, y: 4'd3, eq: 12'h511, er: 8'h15, edz: 1'b0};
    vecs[3] = '{q: 9'd300, r: 4'd9,  y: 4'd0, eq: 12'h000, er: 8'h00, edz: 1'b1};
    vecs[4] = '{q: 9'd100, r: 4'd10, y: 4'd7, eq: 12'h100, er: 8'h10, edz: 1'b0};
    vecs[5] = '{q: 9'd0,   r: 4'd0,  y: 4'd1, eq: 12'h000, er: 8'h00, edz: 1'b0};
    vecs[6] = '{q: 9'd511, r: 4'd15, y: 4'd0, eq: 12'h000, er: 8'h00, edz: 1'b1};
    vecs[7] = '{q: 9'd99,  r: 4'd9,  y: 4'd2, eq: 12'h099, er: 8'h09, edz: 1'b0};

    RST = 1'b1; START = 1'b0; Q = '0; R = '0; Y = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_q_bcd", 32'(Q_BCD), 32'd0);
    chk("rst_r_bcd", 32'(R_BCD), 32'd0);
    chk("rst_dz", 32'(DZ), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Table vectors (includes divide-by-zero followed by a valid conversion).
    for (int i = 0; i < 8; i++) begin
      conv(vecs[i].q, vecs[i].r, vecs[i].y, vecs[i].eq, vecs[i].er, vecs[i].edz);
    end

    // START during SHIFT is ignored; results hold during SHIFT; single DONE.
    d0 = done_cnt;
    begin
      exp_t e;
      e.eq = 12'h042; e.er = 8'h07; e.edz = 1'b0;
      Q = 9'd42; R = 4'd7; Y = 4'd6; START = 1'b1;
      exp_q.push_back(e);
      @(negedge CLK); START = 1'b0;           // after edge n
      repeat (3) @(negedge CLK);               // after edge n+3
      Q = 9'd321; R = 4'd3; Y = 4'd0; START = 1'b1;
      @(negedge CLK); START = 1'b0;           // after edge n+4
      chk("busy_mid_shift", 32'(BUSY), 32'd1);
      chk("hold_q_bcd_mid_shift", 32'(Q_BCD), 32'h099);
      chk("hold_r_bcd_mid_shift", 32'(R_BCD), 32'h09);
      repeat (15) @(negedge CLK);
      chk("single_done_pulse", 32'(done_cnt - d0), 32'd1);
      chk("idle_after_ignored_start", 32'(BUSY), 32'd0);
    end

    // Asynchronous reset mid-SHIFT aborts the conversion.
    Q = 9'd77; R = 4'd5; Y = 4'd9; START = 1'b1;
    @(negedge CLK); START = 1'b0;             // after edge n
    repeat (4) @(negedge CLK);                 // after edge n+4
    chk("busy_before_rst", 32'(BUSY), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_busy", 32'(BUSY), 32'd0);
    chk("async_rst_q_bcd", 32'(Q_BCD), 32'd0);
    chk("async_rst_r_bcd", 32'(R_BCD), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    d0 = done_cnt;
    repeat (15) @(negedge CLK);
    chk("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
    conv(9'd77, 4'd5, 4'd9, 12'h077, 8'h05, 1'b0);

    // Back-to-back sweep over every quotient, remainders cycling 0..15.
    for (int v = 0; v < 512; v++) begin
      conv(9'(v), 4'(v % 16), 4'd1, ref_q(v), ref_r(v % 16), 1'b0);
    end

    repeat (2) @(negedge CLK);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
